// File: rtl/booth_r4_control.sv
// booth_r4_control: sequencer for a Booth radix-4 multiplier.
// It issues the c0..c6 datapath strobes, steps through N/2 add/shift iterations and then unloads the product.
module booth_r4_control #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    q_bits,
  output logic          c0,
  output logic          c1,
  output logic          c2,
  output logic          c3,
  output logic          c4,
  output logic          c5,
  output logic          c6,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);
  typedef enum logic [2:0] {IDLE, INIT, ADD, SHIFT, OUT_A, OUT_Q, DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(N / 2);
  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          add;
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    iter_q  <= reset ? '0 : iter_d;
  end
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE:  state_d = start ? INIT : IDLE;
      INIT: begin
        state_d = ADD;
        iter_d  = '0;
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        iter_d  = iter_q + CW'(1);
        state_d = (iter_d == LAST) ? OUT_A : ADD;
      end
      OUT_A: state_d = OUT_Q;
      OUT_Q: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Only the adder strobes look at the recoding bits, and only during ADD.
  always_comb begin
    add  = state_q == ADD;
    c0   = state_q == INIT;
    c1   = add && q_bits[2] && !(&q_bits[1:0]);
    c2   = add && (q_bits != 3'b000) && (q_bits != 3'b111);
    c3   = add && ((q_bits == 3'b011) || (q_bits == 3'b100));
    c4   = state_q == SHIFT;
    c5   = state_q == OUT_A;
    c6   = state_q == OUT_Q;
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  assign iter = iter_q;
endmodule

// File: tb/tb_booth_r4_control.sv
// tb_booth_r4_control: random and directed stimulus checked every cycle against a phase-count reference model.
module tb_booth_r4_control;
  localparam int N  = 8;
  localparam int CW = 3;
  logic          clk = 0;
  logic          reset, start;
  logic [2:0]    q_bits;
  logic          c0, c1, c2, c3, c4, c5, c6, busy, done;
  logic [CW-1:0] iter;
  int tests = 0;
  int fails = 0;
  int ph = 0;
  int m_iter = 0;

  booth_r4_control #(.N(N), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .q_bits(q_bits),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
    .busy(busy), .done(done), .iter(iter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (phase %0d)", tag, got, exp, ph);
    end
  endtask

  // Signed Booth digit selected by the three recoding bits.
  function automatic int digit(input logic [2:0] q);
    return int'(q[1]) + int'(q[0]) - 2 * int'(q[2]);
  endfunction

  // ph counts cycles since start was sampled: 1 INIT, even 2..N ADD, odd 3..N+1 SHIFT, then OUT_A, OUT_Q, DONE.
  task automatic step(input logic r, input logic s, input logic [2:0] q);
    logic add;
    int d;
    logic [8:0] e;
    reset = r; start = s; q_bits = q;
    #1;
    add = ph >= 2 && ph <= N + 1 && ph % 2 == 0;
    d = digit(q);
    e = {ph == 1, add && d < 0, add && d != 0, add && (d == 2 || d == -2),
         ph >= 3 && ph <= N + 1 && ph % 2 == 1, ph == N + 2, ph == N + 3, ph != 0, ph == N + 4};
    check("ctl", {c0, c1, c2, c3, c4, c5, c6, busy, done}, e);
    check("iter", iter, m_iter);
    check("excl", (int'(c0) + int'(c2) + int'(c4) + int'(c5) + int'(c6)) <= 1, 1);
    @(posedge clk);
    if (r) begin
      ph = 0;
      m_iter = 0;
    end else begin
      if (ph == 1) m_iter = 0;
      if (ph >= 3 && ph <= N + 1 && ph % 2 == 1) m_iter++;
      ph = (ph == 0) ? (s ? 1 : 0) : (ph == N + 4 ? 0 : ph + 1);
    end
    #1;
  endtask

  // One full run from IDLE; qseq holds the recoding bits per ADD, extra_ph re-pulses start at that phase.
  task automatic run(input logic [3*(N/2)-1:0] qseq, input int extra_ph, input logic hold);
    int n;
    logic [2:0] q;
    step(0, 1, 3'($urandom));
    n = 1;
    while (!done && n < 40) begin
      q = (ph >= 2 && ph <= N + 1 && ph % 2 == 0) ? qseq[3*((ph-2)/2) +: 3] : 3'($urandom);
      step(0, hold || ph == extra_ph, q);
      n++;
    end
    check("latency", n, N + 4);
    check("iter_done", iter, N / 2);
    step(0, hold, 3'($urandom));
  endtask

  initial begin
    reset = 1; start = 0; q_bits = 0;
    @(posedge clk);
    #1;
    step(1, 1, 3'b011);
    step(1, 0, 3'b101);
    repeat (3) step(0, 0, 3'($urandom));
    run('0, -1, 0);
    run({3'b110, 3'b100, 3'b011, 3'b001}, -1, 0);
    run({4{3'b010}}, -1, 0);
    run({4{3'b101}}, -1, 0);
    run({4{3'b111}}, -1, 0);
    run({4{3'b011}}, 7, 0);
    run({4{3'b100}}, -1, 1);
    run({4{3'b001}}, -1, 0);
    repeat (2) step(0, 0, 3'($urandom));
    step(0, 1, 3'b000);
    step(0, 0, 3'b000);
    step(0, 0, 3'b011);
    step(0, 0, 3'b000);
    step(1, 0, 3'b011);
    step(0, 0, 3'b011);
    run({3'b100, 3'b001, 3'b110, 3'b011}, -1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, 3'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_r4_control.md
Name: booth_r4_control

Overview:
- Control unit (sequencer) for the Booth radix-4 multiplier.
- Issues the c0..c6 control strobes consumed by the accumulator register A, the Q register, the M register, the adder and the output bus.
- Reads the Booth recoding bits {Q[1],Q[0],Q[-1]} from the datapath and steps through the N/2 add/shift iterations.
- Unloads the product as A then Q and raises done for one cycle.

Parameters:
- N, 8, operand width in bits; must be even and >= 2; iterations = N/2.
- CW, 3, iteration counter width; must satisfy 2^CW > N/2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a multiplication; sampled only in IDLE.
- q_bits  input  3  {Q[1],Q[0],Q[-1]} from the datapath; must be stable during ADD.
- c0  output  1  init: clear A, load M and Q, clear Q[-1].
- c1  output  1  adder subtracts the operand (0 = add).
- c2  output  1  A <= sum.
- c3  output  1  adder operand is 2M (0 = M).
- c4  output  1  arithmetic right shift of {A,Q,Q[-1]} by 2.
- c5  output  1  drive A onto the output bus.
- c6  output  1  drive Q onto the output bus.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- iter  output  CW  number of completed iterations.

Behaviour:
- Reset: when reset=1 at a clock edge, the next state is IDLE, iter=0, and all c0..c6, busy and done are 0. This holds mid-operation as well; the partial result is abandoned.
- States: IDLE, INIT, ADD, SHIFT, OUT_A, OUT_Q, DONE. The state is registered.
- Output decode:
  - c0, c4, c5, c6, busy and done are Moore decodes of the state.
  - c1, c2 and c3 are combinational from state==ADD and q_bits.
- IDLE:
  - All strobes are 0.
  - If start=1 the next state is INIT; otherwise stay in IDLE.
- INIT:
  - c0=1 for one cycle and iter is cleared to 0.
  - Next state is ADD.
- ADD (one cycle). Recoding of q_bits:
  - 000 or 111: no operation; c1=c2=c3=0.
  - 001 or 010: +M; c2=1, c1=0, c3=0.
  - 011: +2M; c2=1, c1=0, c3=1.
  - 100: -2M; c2=1, c1=1, c3=1.
  - 101 or 110: -M; c2=1, c1=1, c3=0.
  - Next state is SHIFT.
- SHIFT:
  - c4=1 for one cycle and iter increments by 1.
  - If the incremented iter equals N/2, the next state is OUT_A; otherwise ADD.
- OUT_A: c5=1 for one cycle, then OUT_Q.
- OUT_Q: c6=1 for one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE. iter holds N/2 until the next INIT.
- Strobe exclusivity: at most one of c0, c2, c4, c5, c6 is high in any cycle.
- Latency: with start sampled at edge k, the sequence is INIT at k+1, ADD/SHIFT pairs from k+2 to k+N+1, OUT_A at k+N+2, OUT_Q at k+N+3 and DONE at k+N+4. For N=8, done is high in cycle k+12.
- start while busy: ignored; it has no effect on the state or iter.
- start held high continuously: a new run begins on the cycle after DONE returns to IDLE, i.e. IDLE lasts one cycle between runs.
- reset and start asserted together: reset wins; the block stays in IDLE.
- q_bits outside ADD: ignored.

Test Plan:
- Reset check: hold reset=1 for 2 cycles in any state -> all c0..c6=0, busy=0, done=0, iter=0. Release reset with start=0 -> the block stays in IDLE.
- Single run, q_bits held at 000 (N=8): pulse start -> c0 high for 1 cycle, then four ADD cycles with c2=0 each followed by c4=1, then c5, then c6, then done in cycle 12 after start. iter reads 4 at DONE.
- Recoding sweep: drive q_bits 001, 011, 100, 110 in the four successive ADD cycles -> (c2,c1,c3) = (1,0,0), (1,0,1), (1,1,1), (1,1,0). Separate runs with 010, 101 and 111 -> (1,0,0), (1,1,0) and (0,0,0).
- Start while busy: pulse start again during the third SHIFT -> no restart, done still appears exactly at cycle 12 from the first start. Then hold start=1 through DONE -> a new INIT appears 2 cycles after DONE.
- Reset mid-operation: assert reset during the second ADD with q_bits=011 -> on the next cycle c2=c3=0, state is IDLE, iter=0. A fresh start then completes normally in 12 cycles.
- Exclusivity assertion: over a full run, check every cycle that at most one of c0, c2, c4, c5, c6 is high and that busy=1 exactly from INIT through DONE.
